// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the producer/consumer side of sync_fifo_param.
//   slave  : the FIFO. It takes wr_en/d_in/rd_en and drives data, flags,
//            handshake pulses and occupancy.
//   master : the block that uses the FIFO (the opposite directions).
// Signals:
//   wr_en, d_in      write request and data
//   rd_en            read request
//   d_out            registered read data (1-cycle latency)
//   full, empty, almost_full, almost_empty   registered status flags
//   wr_ack, wr_err, rd_ack, rd_err           previous-cycle request outcome
//   data_count       registered occupancy (0..DEPTH)
//   next_data_count  occupancy after the coming clock edge
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] d_in;
  logic              rd_en;
  logic [DATA_W-1:0] d_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
  logic [CW-1:0]     data_count;
  logic [CW-1:0]     next_data_count;

  modport slave (
    input  wr_en, d_in, rd_en,
    output d_out, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count, next_data_count
  );

  modport master (
    output wr_en, d_in, rd_en,
    input  d_out, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count, next_data_count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with configurable width and depth, programmable
// almost-full/almost-empty thresholds and well-defined simultaneous
// read/write behaviour at both full and empty.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears pointers, count, d_out, flags and
//          handshake pulses (the storage array itself is left untouched)
//   bus    sync_fifo_param_if.slave, see the interface for signal meanings
// Parameters:
//   DATA_W    word width
//   DEPTH     number of entries, power of two, >= 2
//   AF_LEVEL  almost_full when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                reset,
  sync_fifo_param_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] d_out_q;
  logic              full_q, empty_q, almost_full_q, almost_empty_q;
  logic              wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic              wr_accept, rd_accept;

  // A write into a full FIFO is still accepted when a read frees the slot on
  // the same edge; a read from an empty FIFO is never bypassed from d_in.
  always_comb begin
    wr_accept = bus.wr_en && ((count_q != CW'(DEPTH)) || bus.rd_en);
    rd_accept = bus.rd_en && (count_q != '0);
    count_d   = count_q;
    if (wr_accept) count_d = count_d + CW'(1);
    if (rd_accept) count_d = count_d - CW'(1);
  end

  // NOTE: the storage array has no reset; it is never read before a write has
  // filled the addressed slot, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_ptr_q] <= bus.d_in;
    end
  end

  // NOTE: non-blocking assignments make d_out sample the pre-edge contents of
  // mem_q, so a full-FIFO read+write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      d_out_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_ack_q       <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_err_q       <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_accept) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        d_out_q  <= mem_q[rd_ptr_q];
      end
      count_q        <= count_d;
      // Flags decode the next count so they line up with data_count.
      full_q         <= (count_d == CW'(DEPTH));
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= CW'(AF_LEVEL));
      almost_empty_q <= (count_d <= CW'(AE_LEVEL));
      wr_ack_q       <= wr_accept;
      wr_err_q       <= bus.wr_en && !wr_accept;
      rd_ack_q       <= rd_accept;
      rd_err_q       <= bus.rd_en && !rd_accept;
    end
  end

  assign bus.d_out           = d_out_q;
  assign bus.full            = full_q;
  assign bus.empty           = empty_q;
  assign bus.almost_full     = almost_full_q;
  assign bus.almost_empty    = almost_empty_q;
  assign bus.wr_ack          = wr_ack_q;
  assign bus.wr_err          = wr_err_q;
  assign bus.rd_ack          = rd_ack_q;
  assign bus.rd_err          = rd_err_q;
  assign bus.data_count      = count_q;
  assign bus.next_data_count = count_d;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed stimulus for sync_fifo_param (DATA_W=32, DEPTH=8, AF=6, AE=2).
// A queue-based reference model tracks what the FIFO must hold; a compare
// process checks every DUT output against it on each falling edge, and the
// directed sequence adds literal expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic clk;
  logic reset;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_dout;
  logic exp_wack, exp_werr, exp_rack, exp_rerr;
  bit   model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      exp_dout    = '0;
      exp_wack    = 1'b0;
      exp_werr    = 1'b0;
      exp_rack    = 1'b0;
      exp_rerr    = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit wa, ra;
      wa = bus.wr_en && (q.size() < DEPTH || bus.rd_en);
      ra = bus.rd_en && (q.size() > 0);
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(bus.d_in);
      exp_wack = wa;
      exp_werr = bus.wr_en && !wa;
      exp_rack = ra;
      exp_rerr = bus.rd_en && !ra;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      int sz, nxt;
      sz = q.size();
      check("d_out",        64'(bus.d_out),        64'(exp_dout));
      check("data_count",   64'(bus.data_count),   64'(sz));
      check("full",         64'(bus.full),         64'(sz == DEPTH));
      check("empty",        64'(bus.empty),        64'(sz == 0));
      check("almost_full",  64'(bus.almost_full),  64'(sz >= AF));
      check("almost_empty", 64'(bus.almost_empty), 64'(sz <= AE));
      check("wr_ack",       64'(bus.wr_ack),       64'(exp_wack));
      check("wr_err",       64'(bus.wr_err),       64'(exp_werr));
      check("rd_ack",       64'(bus.rd_ack),       64'(exp_rack));
      check("rd_err",       64'(bus.rd_err),       64'(exp_rerr));
      if (!reset) begin
        nxt = sz;
        if (bus.wr_en && (sz < DEPTH || bus.rd_en)) nxt++;
        if (bus.rd_en && sz > 0) nxt--;
        check("next_data_count", 64'(bus.next_data_count), 64'(nxt));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge, are captured by the next
  // rising edge, and the task returns 1 unit later with that edge's results.
  task automatic step(input logic rst, input logic wr,
                      input logic [DATA_W-1:0] d, input logic rd);
    reset     = rst;
    bus.wr_en = wr;
    bus.d_in  = d;
    bus.rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.d_in  = '0;
    bus.rd_en = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_count", 64'(bus.data_count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_dout",  64'(bus.d_out), 64'd0);

    // Read on empty
    step(1'b0, 1'b0, '0, 1'b1);
    check("empty_rd_err",  64'(bus.rd_err), 64'd1);
    check("empty_rd_ack",  64'(bus.rd_ack), 64'd0);
    check("empty_rd_dout", 64'(bus.d_out),  64'd0);
    check("empty_rd_cnt",  64'(bus.data_count), 64'd0);

    // Nine writes 0x11..0x99: last is rejected
    for (int i = 0; i < 9; i++) begin
      int c;
      step(1'b0, 1'b1, DATA_W'((i + 1) * 32'h11), 1'b0);
      c = (i < 8) ? i + 1 : 8;
      check("fill_wr_ack", 64'(bus.wr_ack), 64'(i < 8));
      check("fill_wr_err", 64'(bus.wr_err), 64'(i == 8));
      check("fill_ae",     64'(bus.almost_empty), 64'(c < 3));
      check("fill_af",     64'(bus.almost_full),  64'(c >= 6));
      check("fill_full",   64'(bus.full),         64'(c == 8));
    end

    // Full: read and write together, oldest word comes out
    step(1'b0, 1'b1, 32'hAA, 1'b1);
    check("full_rw_dout",  64'(bus.d_out), 64'h11);
    check("full_rw_cnt",   64'(bus.data_count), 64'd8);
    check("full_rw_wack",  64'(bus.wr_ack), 64'd1);
    check("full_rw_rack",  64'(bus.rd_ack), 64'd1);

    // Drain: 0x22..0x88 then 0xAA
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check("drain_dout", 64'(bus.d_out),
            (i < 7) ? 64'((i + 2) * 32'h11) : 64'hAA);
    end
    check("drain_empty", 64'(bus.empty), 64'd1);

    // Empty: read and write together, read rejected, no bypass
    step(1'b0, 1'b1, 32'hBB, 1'b1);
    check("empty_rw_wack", 64'(bus.wr_ack), 64'd1);
    check("empty_rw_rerr", 64'(bus.rd_err), 64'd1);
    check("empty_rw_cnt",  64'(bus.data_count), 64'd1);
    check("empty_rw_dout", 64'(bus.d_out), 64'hAA);
    step(1'b0, 1'b0, '0, 1'b1);
    check("bb_dout", 64'(bus.d_out), 64'hBB);

    // Interleaved stream of 24 words; the model checks ordering across wrap
    begin
      int k;
      k = 0;
      for (int i = 0; i < 60; i++) begin
        logic wr, rd;
        wr = (k < 24) && (i % 4 != 3);
        rd = (i >= 3) && (i % 3 != 0);
        step(1'b0, wr, DATA_W'(32'h1000 + k), rd);
        if (wr) k++;
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
      check("stream_empty", 64'(bus.empty), 64'd1);
      check("stream_last",  64'(bus.d_out), 64'h1017);
    end

    // Reset with five words stored, concurrent requests ignored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'(32'h500 + i), 1'b0);
    check("pre_rst_cnt", 64'(bus.data_count), 64'd5);
    step(1'b1, 1'b1, 32'hFF, 1'b1);
    check("mid_rst_cnt",   64'(bus.data_count), 64'd0);
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    check("mid_rst_acks",  64'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 64'd0);
    check("mid_rst_dout",  64'(bus.d_out), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("post_rst_rerr", 64'(bus.rd_err), 64'd1);
    check("post_rst_dout", 64'(bus.d_out), 64'd0);

    step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
